// File: rtl/alu_pkg.sv
// Shared definitions for the Y86 execute-stage ALU: op codes and default datapath width.
package alu_pkg;
  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_e;
endpackage

// File: rtl/alu_adder.sv
// WIDTH-bit adder with carry-in; exposes the carries into and out of the MSB so the
// caller can derive two's-complement overflow as their XOR.
module alu_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_msb_o,
  output logic             c_out_o
);
  logic [WIDTH-2:0] lo;
  logic             msb;

  // Split at the MSB so the carry into the sign bit is visible.
  assign {c_msb_o, lo} = {1'b0, a_i[WIDTH-2:0]} + {1'b0, b_i[WIDTH-2:0]}
                       + {{(WIDTH-1){1'b0}}, cin_i};
  assign {c_out_o, msb} = {1'b0, a_i[WIDTH-1]} + {1'b0, b_i[WIDTH-1]} + {1'b0, c_msb_o};
  assign sum_o = {msb, lo};
endmodule

// File: rtl/y86_alu.sv
// Registered 64-bit Y86 ALU (ADD/SUB/AND/XOR) with signed-overflow flag, 1-cycle latency.
// Optional ALU_FLAGS_EN adds registered zf/sf outputs completing {OF,SF,ZF}.
module y86_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       select_line,
`ifdef ALU_FLAGS_EN
  output logic             zf,
  output logic             sf,
`endif
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             out_valid
);
  alu_op_e          op;
  logic             is_sub;
  logic [WIDTH-1:0] b_add, sum;
  logic             c_msb, c_out;
  logic [WIDTH-1:0] out_d, out_q;
  logic             carry_d, carry_q, vld_q;

  assign op     = alu_op_e'(select_line);
  assign is_sub = (op == ALU_SUB);
  assign b_add  = is_sub ? ~b : b;

  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .a_i     (a),
    .b_i     (b_add),
    .cin_i   (is_sub),
    .sum_o   (sum),
    .c_msb_o (c_msb),
    .c_out_o (c_out)
  );

  always_comb begin
    out_d   = sum;
    carry_d = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        out_d   = sum;
        carry_d = c_msb ^ c_out;
      end
      ALU_AND: out_d = a & b;
      ALU_XOR: out_d = a ^ b;
      default: out_d = sum;
    endcase
  end

  // Result regs hold on idle cycles; only the valid flag drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        out_q   <= out_d;
        carry_q <= carry_d;
      end
    end
  end

  assign out       = out_q;
  assign carry     = carry_q;
  assign out_valid = vld_q;

`ifdef ALU_FLAGS_EN
  logic zf_q, sf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zf_q <= 1'b0;
      sf_q <= 1'b0;
    end else if (in_valid) begin
      zf_q <= (out_d == '0);
      sf_q <= out_d[WIDTH-1];
    end
  end

  assign zf = zf_q;
  assign sf = sf_q;
`endif
endmodule

// File: tb/tb_y86_alu.sv
// Scoreboard bench for y86_alu: driver pushes reference results, negedge monitor pops and compares.
module tb_y86_alu;
  localparam int W = 64;
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

  typedef struct {
    logic [W-1:0] out;
    logic         carry;
    logic         zf;
    logic         sf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic [1:0]   select_line;
  logic [W-1:0] out;
  logic         carry, out_valid;
`ifdef ALU_FLAGS_EN
  logic         zf, sf;
`endif

  y86_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .select_line (select_line),
`ifdef ALU_FLAGS_EN
    .zf          (zf),
    .sf          (sf),
`endif
    .out         (out),
    .carry       (carry),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  exp_t last;
  logic exp_vld;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
  endtask

  // Reference: exact signed arithmetic on sign-extended operands; overflow iff
  // the true result does not fit in W bits.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] sel);
    exp_t e;
    logic signed [W:0] s;
    s = '0;
    e.carry = 1'b0;
    case (sel)
      2'd0: s = $signed({x[W-1], x}) + $signed({y[W-1], y});
      2'd1: s = $signed({x[W-1], x}) - $signed({y[W-1], y});
      default: ;
    endcase
    case (sel)
      2'd0, 2'd1: begin
        e.out   = s[W-1:0];
        e.carry = (s[W] != s[W-1]);
      end
      2'd2: e.out = x & y;
      default: e.out = x ^ y;
    endcase
    e.zf = (e.out == '0);
    e.sf = e.out[W-1];
    return e;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) exp_vld <= 1'b0;
    else     exp_vld <= in_valid;

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, exp_vld});
      if (out_valid) begin
        if (q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_output actual=%h required=none @%0t", out, $time);
        end else begin
          last = q.pop_front();
          check("out", out, last.out);
          check("carry", {{(W-1){1'b0}}, carry}, {{(W-1){1'b0}}, last.carry});
`ifdef ALU_FLAGS_EN
          check("zf", {{(W-1){1'b0}}, zf}, {{(W-1){1'b0}}, last.zf});
          check("sf", {{(W-1){1'b0}}, sf}, {{(W-1){1'b0}}, last.sf});
`endif
        end
      end else begin
        check("hold_out", out, last.out);
        check("hold_carry", {{(W-1){1'b0}}, carry}, {{(W-1){1'b0}}, last.carry});
      end
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] sel);
    in_valid = 1'b1; a = x; b = y; select_line = sel;
    q.push_back(model(x, y, sel));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); select_line = 2'($urandom);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return MAXP;
      1: return MINN;
      2: return '0;
      3: return '1;
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  initial begin
    last = '{out: '0, carry: 1'b0, zf: 1'b0, sf: 1'b0};
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; select_line = 2'd0;
    #2;
    check("rst_out", out, '0);
    check("rst_carry", {{(W-1){1'b0}}, carry}, '0);
    check("rst_valid", {{(W-1){1'b0}}, out_valid}, '0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    send(64'd3, 64'd5, 2'b00);
    send(MAXP, 64'd1, 2'b00);
    send(64'd10, 64'd8, 2'b01);
    send(MINN, 64'd1, 2'b01);
    send(64'd0, 64'd1, 2'b01);
    send(64'hF0F0, 64'hFF00, 2'b10);
    send(64'hF0F0, 64'hFF00, 2'b11);
    send(64'd5, 64'd5, 2'b01);
    send(64'd1, 64'd2, 2'b01);
    idle(2);

    // Back-to-back one per op, then hold
    send(64'd100, 64'd23, 2'b00);
    send(64'd100, 64'd23, 2'b01);
    send(64'd100, 64'd23, 2'b10);
    send(64'd100, 64'd23, 2'b11);
    idle(3);

    // Asynchronous reset while holding a valid result of 5
    send(64'd2, 64'd3, 2'b00);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_out", out, '0);
    check("midrst_carry", {{(W-1){1'b0}}, carry}, '0);
    check("midrst_valid", {{(W-1){1'b0}}, out_valid}, '0);
    q.delete();
    last = '{out: '0, carry: 1'b0, zf: 1'b0, sf: 1'b0};
    #3 rst = 1'b0;
    @(posedge clk); #1;
    send(64'd7, 64'd9, 2'b11);
    idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(rnd_operand(), rnd_operand(), 2'($urandom));
    end
    idle(3);

    chk_cnt++;
    if (q.size() == 0) pass_cnt++;
    else $display("FAIL missing_outputs actual=%0d required=0", q.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
